// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
//   Multi-cycle restoring divider for the DIV microroutine. The control unit
//   pulses i_start with ACC as the dividend and BR as the divisor, then waits
//   for o_done. This block has its own shift and subtract registers, so the
//   shared ALU stays free while a division runs.
//
//   Timing, with start accepted on the edge that ends cycle T:
//     PREP at T+1, ITER at T+2..T+WIDTH+1, FIX at T+WIDTH+2,
//     DONE at T+WIDTH+3.
//     A zero divisor skips ITER and FIX, so DONE is at T+2.
//
// Parameters
//   WIDTH          operand/result width, legal range 4..32 (default 16)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-high; aborts any operation
//   i_start        request; sampled only in IDLE
//   i_signed_mode  signed division select; sampled with i_start
//   i_dividend     dividend (ACC); sampled with i_start
//   i_divisor      divisor (BR); sampled with i_start
//   o_busy         high whenever the sequencer is not in IDLE
//   o_done         one-cycle pulse; results are valid from this cycle on
//   o_quotient     registered quotient
//   o_remainder    registered remainder
//   o_div_by_zero  registered zero-divisor flag for the last operation
//
// Build option
//   DIV_SIGNED_EN  When defined, i_signed_mode=1 gives signed division.
//                  The quotient truncates toward zero and the remainder
//                  takes the sign of the dividend. When not defined,
//                  i_signed_mode is ignored and all division is unsigned.
// ---------------------------------------------------------------------------
module div_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_signed_mode,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_dvd_raw;    // captured dividend
    logic [WIDTH-1:0] r_dvs_raw;    // captured divisor
    logic [WIDTH-1:0] r_q;          // working dividend, becomes the quotient
    logic [WIDTH-1:0] r_d;          // working divisor magnitude
    logic [WIDTH-1:0] r_pr;         // partial remainder
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    // The partial remainder is WIDTH+1 bits wide during the trial subtract.
    // It is stored in WIDTH bits because, after keep or restore, it is always
    // smaller than the divisor. Its top bit is therefore always zero.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;

    assign w_shift = {r_pr, r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_d};
    assign w_fits  = ~w_trial[WIDTH];       // non-negative difference: keep it

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

`ifdef DIV_SIGNED_EN
    logic r_signed;
    logic r_neg_q;
    logic r_neg_r;
    logic w_dvd_neg;
    logic w_dvs_neg;

    assign w_dvd_neg = r_signed & r_dvd_raw[WIDTH-1];
    assign w_dvs_neg = r_signed & r_dvs_raw[WIDTH-1];
    // Magnitudes are WIDTH-bit unsigned values. The most-negative value
    // negates to itself, and that bit pattern is its correct magnitude.
    assign w_dvd_mag = w_dvd_neg ? -r_dvd_raw : r_dvd_raw;
    assign w_dvs_mag = w_dvs_neg ? -r_dvs_raw : r_dvs_raw;
    assign w_q_fix   = r_neg_q ? -r_q  : r_q;
    assign w_r_fix   = r_neg_r ? -r_pr : r_pr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_signed <= i_signed_mode;
        end else if (r_state == S_PREP) begin
            r_neg_q  <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r  <= w_dvd_neg;
        end
    end
`else
    // The port remains for interface compatibility but has no function here.
    logic w_unused_signed;
    assign w_unused_signed = i_signed_mode;

    assign w_dvd_mag = r_dvd_raw;
    assign w_dvs_mag = r_dvs_raw;
    assign w_q_fix   = r_q;
    assign w_r_fix   = r_pr;
`endif

    // NOTE: sequential state uses non-blocking (<=) assignments only. Every
    // register then samples the values from before the edge, which is what
    // lets the shift/subtract step read r_pr and r_q while it overwrites them.
    always_ff @(posedge clk) begin
        // NOTE: reset clears the datapath registers as well as the control
        // state. An aborted operation then leaves no stale operands behind.
        if (rst) begin
            r_state     <= S_IDLE;
            r_dvd_raw   <= '0;
            r_dvs_raw   <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_pr        <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_dvd_raw <= i_dividend;
                        r_dvs_raw <= i_divisor;
                        r_busy    <= 1'b1;
                        r_state   <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (r_dvs_raw == '0) begin
                        r_dbz       <= 1'b1;
                        r_quotient  <= '1;
                        r_remainder <= r_dvd_raw;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_q     <= w_dvd_mag;
                        r_d     <= w_dvs_mag;
                        r_pr    <= '0;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_dbz   <= 1'b0;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    // One quotient bit per cycle, MSB first. The dividend
                    // bits shift out of r_q as the quotient bits shift in.
                    r_pr <= w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_q  <= {r_q[WIDTH-2:0], w_fits};
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    r_quotient  <= w_q_fix;
                    r_remainder <= w_r_fix;
                    r_done      <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_div_sequencer
//   Directed test of div_sequencer at WIDTH=16. Expected values are computed
//   by hand. Inputs change 1 ns after a rising edge, and outputs are sampled
//   at the same point. In the loops below, "cycle c" counts from the cycle
//   that follows the start-accept edge (c=1 is T+1).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_sequencer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic             i_signed_mode;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_by_zero;

    div_sequencer #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_signed_mode (i_signed_mode),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one operation from IDLE. Check the busy rise, the done latency
    // and the results, then confirm the sequencer is back in IDLE.
    task automatic run_op(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                          input logic sm, input int exp_lat, input logic [15:0] exp_q,
                          input logic [15:0] exp_r, input logic exp_dbz);
        int cyc;
        i_dividend    = dvd;
        i_divisor     = dvs;
        i_signed_mode = sm;
        i_start       = 1'b1;
        step();
        i_start = 1'b0;
        check({tag, " busy_rise"}, 32'(o_busy), 32'd1);
        cyc = 1;
        while (!o_done && cyc < 40) begin
            step();
            cyc++;
        end
        check({tag, " done_seen"}, 32'(o_done), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " quotient"}, 32'(o_quotient), 32'(exp_q));
        check({tag, " remainder"}, 32'(o_remainder), 32'(exp_r));
        check({tag, " dbz"}, 32'(o_div_by_zero), 32'(exp_dbz));
        step();
        check({tag, " busy_fall"}, 32'(o_busy), 32'd0);
        check({tag, " done_pulse"}, 32'(o_done), 32'd0);
    endtask

    int n_done;
    int first_done;
    int done_at [4];

    initial begin
        rst           = 1'b1;
        i_start       = 1'b0;
        i_signed_mode = 1'b0;
        i_dividend    = '0;
        i_divisor     = '0;
        repeat (3) step();
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset done", 32'(o_done), 32'd0);
        check("reset quotient", 32'(o_quotient), 32'd0);
        check("reset remainder", 32'(o_remainder), 32'd0);
        check("reset dbz", 32'(o_div_by_zero), 32'd0);
        rst = 1'b0;
        step();

        // Unsigned 100/7 = 14 r 2
        run_op("u100_7", 16'h0064, 16'h0007, 1'b0, 19, 16'h000E, 16'h0002, 1'b0);
        // Zero divisor, then a normal divide clears the flag
        run_op("div0", 16'h04D2, 16'h0000, 1'b0, 2, 16'hFFFF, 16'h04D2, 1'b1);
        run_op("u9_3", 16'h0009, 16'h0003, 1'b0, 19, 16'h0003, 16'h0000, 1'b0);

`ifdef DIV_SIGNED_EN
        run_op("s-7_2", 16'hFFF9, 16'h0002, 1'b1, 19, 16'hFFFD, 16'hFFFF, 1'b0);
        run_op("smin_m1", 16'h8000, 16'hFFFF, 1'b1, 19, 16'h8000, 16'h0000, 1'b0);
`else
        // signed_mode ignored: 65529/2 = 32764 r 1
        run_op("s-7_2", 16'hFFF9, 16'h0002, 1'b1, 19, 16'h7FFC, 16'h0001, 1'b0);
        // 32768/65535 = 0 r 32768
        run_op("u8000_ffff", 16'h8000, 16'hFFFF, 1'b0, 19, 16'h0000, 16'h8000, 1'b0);
`endif
        // Largest quotient: 65535/1
        run_op("uffff_1", 16'hFFFF, 16'h0001, 1'b0, 19, 16'hFFFF, 16'h0000, 1'b0);

        // Second start at T+5 must be ignored. 200/9 = 22 r 2.
        i_dividend    = 16'd200;
        i_divisor     = 16'd9;
        i_signed_mode = 1'b0;
        i_start       = 1'b1;
        step();
        i_start    = 1'b0;
        n_done     = 0;
        first_done = 0;
        for (int c = 1; c <= 45; c++) begin
            if (o_done) begin
                n_done++;
                if (n_done == 1) first_done = c;
            end
            if (c == 5) begin
                i_start    = 1'b1;
                i_dividend = 16'h0050;
                i_divisor  = 16'h0003;
            end else begin
                i_start = 1'b0;
            end
            step();
        end
        check("ignore_start done_count", 32'(n_done), 32'd1);
        check("ignore_start done_cycle", 32'(first_done), 32'd19);
        check("ignore_start quotient", 32'(o_quotient), 32'h0016);
        check("ignore_start remainder", 32'(o_remainder), 32'h0002);

        // Reset during cycle T+8 aborts. Outputs read 0 at T+9 and no done follows.
        i_dividend = 16'h1234;
        i_divisor  = 16'h0005;
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 1; c < 8; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", 32'(o_busy), 32'd0);
        check("abort done", 32'(o_done), 32'd0);
        check("abort quotient", 32'(o_quotient), 32'd0);
        check("abort remainder", 32'(o_remainder), 32'd0);
        check("abort dbz", 32'(o_div_by_zero), 32'd0);
        n_done = 0;
        for (int c = 9; c <= 30; c++) begin
            if (o_done || o_busy) n_done++;
            step();
        end
        check("abort no_activity", 32'(n_done), 32'd0);
        run_op("post_abort", 16'hFFFF, 16'h0001, 1'b0, 19, 16'hFFFF, 16'h0000, 1'b0);

        // start held high: done every WIDTH+4 cycles. 16/4 = 4 r 0.
        i_dividend = 16'h0010;
        i_divisor  = 16'h0004;
        i_start    = 1'b1;
        n_done     = 0;
        for (int c = 0; c <= 65; c++) begin
            if (o_done) begin
                if (n_done < 4) done_at[n_done] = c;
                n_done++;
                check("held quotient", 32'(o_quotient), 32'h0004);
                check("held remainder", 32'(o_remainder), 32'h0000);
            end
            step();
        end
        i_start = 1'b0;
        check("held done_count", 32'(n_done), 32'd3);
        check("held first_done", 32'(done_at[0]), 32'd19);
        check("held spacing1", 32'(done_at[1] - done_at[0]), 32'd20);
        check("held spacing2", 32'(done_at[2] - done_at[1]), 32'd20);
        for (int c = 0; c < 60 && o_busy; c++) step();
        check("held drain idle", 32'(o_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
